// File: rtl/i2s_audio_tx.sv
// I2S (Philips) transmitter. A fractional phase accumulator generates the
// bit clock from the system clock, so the frame rate is exact on average.
// Each frame latches one stereo sample, converts it to the slot width,
// applies volume, optionally mixes to mono, and shifts it out MSB first.
module i2s_audio_tx #(
  parameter int CLK_HZ_0    = 31500000,
  parameter int CLK_HZ_1    = 32940000,
  parameter int SAMPLE_RATE = 48000,
  parameter int IN_WIDTH    = 18,
  parameter int SLOT_WIDTH  = 16,
  parameter int STEREO      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_sel,
  input  logic [IN_WIDTH-1:0] audio_l,
  input  logic [IN_WIDTH-1:0] audio_r,
  input  logic [1:0]          volume,
  output logic                sample_req,
  output logic                hp_bck,
  output logic                hp_ws,
  output logic                hp_din
);

  localparam int INC     = 2 * SAMPLE_RATE * 2 * SLOT_WIDTH;
  localparam int MOD_MAX = (CLK_HZ_0 > CLK_HZ_1) ? CLK_HZ_0 : CLK_HZ_1;
  localparam int ACC_W   = $clog2(MOD_MAX + INC + 1);
  localparam int FRAME_W = 2 * SLOT_WIDTH;
  localparam int P_W     = $clog2(FRAME_W);
  localparam int MW      = (IN_WIDTH > SLOT_WIDTH) ? IN_WIDTH : SLOT_WIDTH;
  localparam int SH_R    = (IN_WIDTH > SLOT_WIDTH) ? (IN_WIDTH - SLOT_WIDTH) : 0;
  localparam int SH_L    = (IN_WIDTH < SLOT_WIDTH) ? (SLOT_WIDTH - IN_WIDTH) : 0;

  // Each BCK half-period must span at least two system clocks.
  if ((CLK_HZ_0 < 2 * INC) || (CLK_HZ_1 < 2 * INC)) begin : g_bad_ratio
    $error("i2s_audio_tx: system clock too slow for requested bit clock");
  end

  // Fit a core sample into the slot: drop LSBs or left-justify with zeros.
  function automatic logic signed [SLOT_WIDTH-1:0] f_to_slot(
    input logic signed [IN_WIDTH-1:0] x
  );
    logic signed [MW-1:0] t;
    t = MW'(x);
    t = t >>> SH_R;
    t = t <<< SH_L;
    return t[SLOT_WIDTH-1:0];
  endfunction

  // Volume scaling by arithmetic shift; code 0 mutes.
  function automatic logic signed [SLOT_WIDTH-1:0] f_volume(
    input logic signed [SLOT_WIDTH-1:0] s,
    input logic [1:0]                   vol
  );
    logic signed [SLOT_WIDTH-1:0] y;
    case (vol)
      2'd1:    y = s >>> 2;
      2'd2:    y = s >>> 1;
      2'd3:    y = s;
      default: y = '0;
    endcase
    return y;
  endfunction

  logic [ACC_W-1:0]          r_acc;
  logic                      r_first;
  logic [P_W-1:0]            r_p;
  logic [FRAME_W-1:0]        r_shift;

  logic [ACC_W-1:0]          w_sum;
  logic [ACC_W-1:0]          w_mod;
  logic                      w_tick;
  logic                      w_fall;
  logic                      w_wrap;
  logic [P_W-1:0]            w_p_next;
  logic signed [IN_WIDTH:0]  w_mono_sum;
  logic signed [IN_WIDTH-1:0] w_mono;
  logic signed [IN_WIDTH-1:0] w_l_src;
  logic signed [IN_WIDTH-1:0] w_r_src;
  logic signed [SLOT_WIDTH-1:0] w_slot_l;
  logic signed [SLOT_WIDTH-1:0] w_slot_r;
  logic [FRAME_W-1:0]        w_frame_new;

  assign w_sum  = r_acc + ACC_W'(INC);
  assign w_mod  = clk_sel ? ACC_W'(CLK_HZ_1) : ACC_W'(CLK_HZ_0);
  assign w_tick = (w_sum >= w_mod);
  assign w_fall = w_tick & hp_bck;

  // Frame boundary: normal wrap, or the very first falling edge after reset.
  assign w_wrap   = r_first | (r_p == P_W'(FRAME_W - 1));
  assign w_p_next = w_wrap ? '0 : r_p + P_W'(1);

  // Mono mix: one extra bit of headroom, then halve; cannot overflow.
  assign w_mono_sum = {audio_l[IN_WIDTH-1], audio_l} + {audio_r[IN_WIDTH-1], audio_r};
  assign w_mono     = w_mono_sum[IN_WIDTH:1];
  assign w_l_src    = (STEREO != 0) ? audio_l : w_mono;
  assign w_r_src    = (STEREO != 0) ? audio_r : w_mono;

  assign w_slot_l    = f_volume(f_to_slot(w_l_src), volume);
  assign w_slot_r    = f_volume(f_to_slot(w_r_src), volume);
  assign w_frame_new = {w_slot_l, w_slot_r};

  // Phase accumulator and bit clock toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      hp_bck <= 1'b0;
    end else if (w_tick) begin
      r_acc  <= w_sum - w_mod;
      hp_bck <= ~hp_bck;
    end else begin
      r_acc  <= w_sum;
    end
  end

  // Bit position, frame latch and serial pin updates on BCK falling events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first    <= 1'b1;
      r_p        <= '0;
      r_shift    <= '0;
      hp_ws      <= 1'b0;
      hp_din     <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      if (w_fall) begin
        r_first <= 1'b0;
        r_p     <= w_p_next;
        hp_ws   <= (w_p_next >= P_W'(SLOT_WIDTH - 1)) && (w_p_next <= P_W'(FRAME_W - 2));
        if (w_wrap) begin
          r_shift    <= w_frame_new;
          hp_din     <= w_frame_new[FRAME_W-1];
          sample_req <= 1'b1;
        end else begin
          r_shift    <= {r_shift[FRAME_W-2:0], 1'b0};
          hp_din     <= r_shift[FRAME_W-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: rate counts, frame decode on BCK rising
// edges, volume, mono mixing and mid-frame reset.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_sel = 1'b0;
  logic [17:0] audio_l = '0;
  logic [17:0] audio_r = '0;
  logic [1:0]  volume = 2'd3;

  logic s_req, s_bck, s_ws, s_din;
  logic m_req, m_bck, m_ws, m_din;

  int checks = 0;
  int errors = 0;

  i2s_audio_tx #(.STEREO(1)) u_dut (
    .clk(clk), .reset(reset), .clk_sel(clk_sel),
    .audio_l(audio_l), .audio_r(audio_r), .volume(volume),
    .sample_req(s_req), .hp_bck(s_bck), .hp_ws(s_ws), .hp_din(s_din)
  );

  i2s_audio_tx #(.STEREO(0)) u_mono (
    .clk(clk), .reset(reset), .clk_sel(clk_sel),
    .audio_l(audio_l), .audio_r(audio_r), .volume(volume),
    .sample_req(m_req), .hp_bck(m_bck), .hp_ws(m_ws), .hp_din(m_din)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for the next frame latch, then collect 32 bits on BCK rising edges.
  task automatic capture(input int chg_at, input logic [1:0] chg_vol,
                         output logic [31:0] sd, output logic [31:0] md,
                         output logic [31:0] ws, output int rises_before);
    int   t;
    int   n;
    logic prev;
    sd = '0; md = '0; ws = '0; rises_before = 0;
    t = 0; n = 0;
    prev = s_bck;
    do begin
      @(negedge clk);
      t++;
      if (s_bck && !prev) rises_before++;
      prev = s_bck;
    end while (!s_req && t < 3000);
    if (!s_req) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    t = 0;
    while (n < 32 && t < 3000) begin
      @(negedge clk);
      t++;
      if (s_bck && !prev) begin
        sd = {sd[30:0], s_din};
        md = {md[30:0], m_din};
        ws = {ws[30:0], s_ws};
        n++;
        if (n == chg_at) volume = chg_vol;
      end
      prev = s_bck;
    end
    if (n < 32) chk("bits_timeout", 32'(n), 32'd32);
  endtask

  // Count frame pulses, BCK rising edges and shortest BCK phase over n clocks.
  task automatic run_rate(input int n, input bit sw,
                          output int reqs, output int rises, output int minph);
    logic prev;
    int   run;
    bit   seen;
    reqs = 0; rises = 0; minph = 1000000;
    prev = s_bck; run = 0; seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sw && (i % 37 == 36)) clk_sel = ~clk_sel;
      if (s_req) reqs++;
      if (s_bck !== prev) begin
        if (s_bck) rises++;
        if (seen && run < minph) minph = run;
        seen = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = s_bck;
    end
  endtask

  initial begin
    logic [31:0] sd, md, ws;
    int rb, reqs, rises, minph, cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bck", 32'(s_bck), 32'd0);
    chk("rst_ws",  32'(s_ws),  32'd0);
    chk("rst_din", 32'(s_din), 32'd0);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_mono_pins", {28'd0, m_req, m_bck, m_ws, m_din}, 32'd0);
    reset = 1'b0;

    // Rate, clk_sel=0: 13125 clk -> 20 frames, 640 BCK rising edges
    run_rate(13125, 1'b0, reqs, rises, minph);
    $display("info rate0 reqs=%0d rises=%0d", reqs, rises);
    chk("rate0_req_pm1",  32'(reqs >= 19 && reqs <= 21), 32'd1);
    chk("rate0_bck_pm1",  32'(rises >= 639 && rises <= 641), 32'd1);

    // Rate, clk_sel=1: 13725 clk -> 20 frames
    clk_sel = 1'b1;
    do_reset();
    run_rate(13725, 1'b0, reqs, rises, minph);
    $display("info rate1 reqs=%0d rises=%0d", reqs, rises);
    chk("rate1_req_pm1", 32'(reqs >= 19 && reqs <= 21), 32'd1);

    // clk_sel toggling mid-run: no BCK phase shorter than 2 clk
    run_rate(4000, 1'b1, reqs, rises, minph);
    $display("info switch minphase=%0d", minph);
    chk("switch_min_phase", 32'(minph >= 2), 32'd1);

    // Stereo data at full volume
    clk_sel = 1'b0;
    audio_l = 18'h10000;
    audio_r = 18'h3FFFC;
    volume  = 2'd3;
    do_reset();
    capture(0, 2'd0, sd, md, ws, rb);
    chk("data_v3", sd, 32'h4000FFFF);
    chk("ws_pattern", ws, 32'h0001FFFE);

    // Mono mix
    audio_r = 18'h08000;
    capture(0, 2'd0, sd, md, ws, rb);
    chk("mono_slots", md, 32'h30003000);
    chk("stereo_v3_b", sd, 32'h40002000);

    // Volume steps; mid-frame change only affects the next frame
    audio_r = 18'h3FFFC;
    volume  = 2'd2;
    capture(0, 2'd0, sd, md, ws, rb);
    chk("data_v2", sd, 32'h2000FFFF);
    volume  = 2'd1;
    capture(10, 2'd0, sd, md, ws, rb);
    chk("data_v1_midchg", sd, 32'h1000FFFF);
    capture(0, 2'd0, sd, md, ws, rb);
    chk("data_v0", sd, 32'h00000000);

    // Reset at p=7 while BCK high
    volume  = 2'd3;
    audio_l = 18'h1FFFC;
    cnt = 0;
    begin
      int   t;
      logic prev;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_req && t < 3000);
      prev = s_bck;
      while (cnt < 8 && t < 6000) begin
        @(negedge clk);
        t++;
        if (s_bck && !prev) cnt++;
        prev = s_bck;
      end
    end
    chk("pre_reset_p7_reached", 32'(cnt), 32'd8);
    chk("pre_reset_din", 32'(s_din), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_pins", {28'd0, s_req, s_bck, s_ws, s_din}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    capture(0, 2'd0, sd, md, ws, rb);
    chk("post_rst_first_fall", 32'(rb), 32'd1);
    chk("post_rst_data", sd, 32'h7FFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
